// File: rtl/z3_master_cycle_pkg.sv
// Shared types and helpers for the Zorro III bus-master cycle initiator.
package z3_master_cycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_TERM,
    ST_ABORT,
    ST_RECOVER
  } state_e;

  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;

  // Active-low lane mask; byte offset i maps to DS_n[3-i] (DS_n[3] = D31:24).
  function automatic logic [3:0] ds_lanes(input logic [1:0] siz, input logic [1:0] a);
    logic [2:0] n;
    logic [3:0] last;
    logic [3:0] ds;
    n    = (siz == SIZ_LONG) ? 3'd4 : {1'b0, siz};
    last = {2'b00, a} + {1'b0, n} - 4'd1;
    ds   = '1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i >= 32'(a) && i <= 32'(last)) ds[2'(3 - i)] = 1'b0;
    end
    return ds;
  endfunction

endpackage

// File: rtl/z3_master_cycle_if.sv
// NCR request side and Zorro master-cycle side of the cycle initiator.
interface z3_master_cycle_if;
  logic       BMASTER;
  logic       cyc_req;
  logic       cyc_read;
  logic [1:0] cyc_siz;
  logic [1:0] cyc_a;
  logic       DTACK_n;
  logic       BERR_n;
  logic       drive_en;
  logic       FCS_n_out;
  logic [3:0] DS_n_out;
  logic       DOE;
  logic       DLATCH;
  logic       SCSI_STERM_n;
  logic       SCSI_BERR_n;
  logic       busy;
  logic       cyc_err;

  modport master (
    input  BMASTER, cyc_req, cyc_read, cyc_siz, cyc_a, DTACK_n, BERR_n,
    output drive_en, FCS_n_out, DS_n_out, DOE, DLATCH, SCSI_STERM_n, SCSI_BERR_n,
           busy, cyc_err
  );

  modport slave (
    output BMASTER, cyc_req, cyc_read, cyc_siz, cyc_a, DTACK_n, BERR_n,
    input  drive_en, FCS_n_out, DS_n_out, DOE, DLATCH, SCSI_STERM_n, SCSI_BERR_n,
           busy, cyc_err
  );
endinterface

// File: rtl/z3_master_cycle_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module z3_master_cycle_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/z3_master_cycle.sv
// Zorro III bus-master cycle initiator: turns one NCR 53C710 DMA request into
// an FCS_n / DS_n / DTACK_n cycle and terminates the NCR with STERM_n or BERR_n.
module z3_master_cycle
  import z3_master_cycle_pkg::*;
#(
  parameter int unsigned ADDR_SETUP = 1,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned RECOVERY   = 1
) (
  input logic            CLK,
  input logic            RESET_n,
  z3_master_cycle_if.master bus
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic       dt_seen_q, dt_seen_d;
  logic       rd_q, rd_d;
  logic [1:0] siz_q, siz_d;
  logic [1:0] a_q, a_d;
  logic       drive_en_q, drive_en_d;
  logic       fcs_n_q, fcs_n_d;
  logic [3:0] ds_n_q, ds_n_d;
  logic       doe_q, doe_d;
  logic       dlatch_q, dlatch_d;
  logic       sterm_n_q, sterm_n_d;
  logic       berr_n_q, berr_n_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       dt_s, be_s;
  logic       go_abort;

  z3_master_cycle_sync2 #(.RST_VAL(1'b1)) u_sync_dtack (
    .clk_i(CLK), .rst_ni(RESET_n), .d_i(bus.DTACK_n), .q_o(dt_s)
  );
  z3_master_cycle_sync2 #(.RST_VAL(1'b1)) u_sync_berr (
    .clk_i(CLK), .rst_ni(RESET_n), .d_i(bus.BERR_n), .q_o(be_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    armed_d    = armed_q | ~bus.cyc_req;
    dt_seen_d  = dt_seen_q;
    rd_d       = rd_q;
    siz_d      = siz_q;
    a_d        = a_q;
    drive_en_d = drive_en_q;
    fcs_n_d    = fcs_n_q;
    ds_n_d     = ds_n_q;
    doe_d      = doe_q;
    dlatch_d   = 1'b0;
    sterm_n_d  = 1'b1;
    berr_n_d   = 1'b1;
    busy_d     = busy_q;
    err_d      = 1'b0;
    go_abort   = 1'b0;

    // A DTACK_n left low by the previous slave must be seen released first.
    if ((state_q == ST_ADDR || state_q == ST_DATA) && dt_s) dt_seen_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.BMASTER && bus.cyc_req && armed_q) begin
          state_d    = ST_ADDR;
          armed_d    = 1'b0;
          dt_seen_d  = 1'b0;
          cnt_d      = '0;
          rd_d       = bus.cyc_read;
          siz_d      = bus.cyc_siz;
          a_d        = bus.cyc_a;
          drive_en_d = 1'b1;
          fcs_n_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_ADDR: begin
        if (!bus.BMASTER) begin
          go_abort = 1'b1;
        end else if (cnt_q == 8'(ADDR_SETUP - 1)) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          ds_n_d  = ds_lanes(siz_q, a_q);
          doe_d   = ~rd_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DATA: begin
        if (!bus.BMASTER || !be_s) begin
          go_abort = 1'b1;
        end else if (!dt_s && dt_seen_q) begin
          state_d   = ST_TERM;
          sterm_n_d = 1'b0;
          dlatch_d  = rd_q;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          go_abort = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_TERM, ST_ABORT: begin
        state_d = ST_RECOVER;
        cnt_d   = '0;
        fcs_n_d = 1'b1;
        ds_n_d  = '1;
        doe_d   = 1'b0;
      end
      ST_RECOVER: begin
        if (cnt_q == 8'(RECOVERY - 1)) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          drive_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_abort) begin
      state_d  = ST_ABORT;
      berr_n_d = 1'b0;
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      armed_q    <= 1'b1;
      dt_seen_q  <= 1'b0;
      rd_q       <= 1'b0;
      siz_q      <= '0;
      a_q        <= '0;
      drive_en_q <= 1'b0;
      fcs_n_q    <= 1'b1;
      ds_n_q     <= '1;
      doe_q      <= 1'b0;
      dlatch_q   <= 1'b0;
      sterm_n_q  <= 1'b1;
      berr_n_q   <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      dt_seen_q  <= dt_seen_d;
      rd_q       <= rd_d;
      siz_q      <= siz_d;
      a_q        <= a_d;
      drive_en_q <= drive_en_d;
      fcs_n_q    <= fcs_n_d;
      ds_n_q     <= ds_n_d;
      doe_q      <= doe_d;
      dlatch_q   <= dlatch_d;
      sterm_n_q  <= sterm_n_d;
      berr_n_q   <= berr_n_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.drive_en     = drive_en_q;
  assign bus.FCS_n_out    = fcs_n_q;
  assign bus.DS_n_out     = ds_n_q;
  assign bus.DOE          = doe_q;
  assign bus.DLATCH       = dlatch_q;
  assign bus.SCSI_STERM_n = sterm_n_q;
  assign bus.SCSI_BERR_n  = berr_n_q;
  assign bus.busy         = busy_q;
  assign bus.cyc_err      = err_q;

endmodule

// File: tb/tb_z3_master_cycle.sv
// Self-checking bench for z3_master_cycle: directed test-plan cycles followed by
// randomized cycles, each checked against per-transaction timing expectations.
module tb_z3_master_cycle;

  localparam int unsigned ADDR_SETUP = 1;
  localparam int unsigned TIMEOUT    = 64;
  localparam int unsigned RECOVERY   = 1;

  localparam int K_DTACK   = 0;
  localparam int K_TIMEOUT = 1;
  localparam int K_BOTH    = 2;
  localparam int K_BMDROP  = 3;
  localparam int K_STALE   = 4;

  logic CLK = 1'b0;
  logic RESET_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  z3_master_cycle_if bus();

  z3_master_cycle #(
    .ADDR_SETUP(ADDR_SETUP),
    .TIMEOUT   (TIMEOUT),
    .RECOVERY  (RECOVERY)
  ) dut (
    .CLK    (CLK),
    .RESET_n(RESET_n),
    .bus    (bus)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Byte offsets a .. a+n-1 (clipped at 3) are active; offset b drives DS_n[3-b].
  function automatic logic [3:0] exp_lanes(input int siz, input int a);
    int n;
    logic [3:0] m;
    n = (siz == 0) ? 4 : siz;
    m = 4'hF;
    for (int b = a; b < a + n && b < 4; b++) m[3-b] = 1'b0;
    return m;
  endfunction

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_fcs"},   bus.FCS_n_out, 1);
    chk({pfx, "_ds"},    bus.DS_n_out, 4'hF);
    chk({pfx, "_drv"},   bus.drive_en, 0);
    chk({pfx, "_doe"},   bus.DOE, 0);
    chk({pfx, "_dlat"},  bus.DLATCH, 0);
    chk({pfx, "_busy"},  bus.busy, 0);
    chk({pfx, "_err"},   bus.cyc_err, 0);
    chk({pfx, "_sterm"}, bus.SCSI_STERM_n, 1);
    chk({pfx, "_berr"},  bus.SCSI_BERR_n, 1);
  endtask

  // Entered at a negedge with the DUT idle, armed, and cyc_req low.
  task automatic run_cycle(input int kind, input int siz, input int a, input logic rd,
                           input int dly, input int hold);
    int lat;
    if (kind == K_STALE) begin
      bus.DTACK_n = 1'b0;
      repeat (3) tick();
    end
    bus.cyc_req  = 1'b1;
    bus.cyc_siz  = 2'(siz);
    bus.cyc_a    = 2'(a);
    bus.cyc_read = rd;
    tick();
    chk("req_fcs_low", bus.FCS_n_out, 0);
    chk("req_busy", bus.busy, 1);
    chk("req_drive_en", bus.drive_en, 1);
    chk("addr_ds_idle", bus.DS_n_out, 4'hF);
    bus.cyc_siz  = 2'($urandom);
    bus.cyc_a    = 2'($urandom);
    bus.cyc_read = 1'($urandom);
    repeat (ADDR_SETUP) tick();
    chk("data_ds_lanes", bus.DS_n_out, exp_lanes(siz, a));
    chk("data_doe", bus.DOE, !rd);
    chk("data_fcs", bus.FCS_n_out, 0);

    if (kind == K_TIMEOUT || kind == K_STALE) begin
      lat = 0;
      for (int t = 1; t <= int'(TIMEOUT) + 4; t++) begin
        tick();
        chk("to_sterm_idle", bus.SCSI_STERM_n, 1);
        if (bus.SCSI_BERR_n == 1'b0) begin
          lat = t;
          break;
        end
      end
      chk("to_latency", lat, TIMEOUT);
      chk("to_cyc_err", bus.cyc_err, 1);
      tick();
      bus.DTACK_n = 1'b1;
    end else begin
      repeat (dly) begin
        tick();
        chk("wait_sterm", bus.SCSI_STERM_n, 1);
      end
      if (kind == K_BMDROP) begin
        bus.BMASTER = 1'b0;
        tick();
        chk("bm_berr", bus.SCSI_BERR_n, 0);
        chk("bm_err", bus.cyc_err, 1);
        chk("bm_sterm", bus.SCSI_STERM_n, 1);
        bus.BMASTER = 1'b1;
      end else begin
        bus.DTACK_n = 1'b0;
        if (kind == K_BOTH) bus.BERR_n = 1'b0;
        repeat (2) begin
          tick();
          chk("sync_sterm", bus.SCSI_STERM_n, 1);
          chk("sync_berr", bus.SCSI_BERR_n, 1);
        end
        tick();
        if (kind == K_BOTH) begin
          chk("both_berr", bus.SCSI_BERR_n, 0);
          chk("both_sterm", bus.SCSI_STERM_n, 1);
          chk("both_err", bus.cyc_err, 1);
        end else begin
          chk("term_sterm", bus.SCSI_STERM_n, 0);
          chk("term_dlatch", bus.DLATCH, rd);
          chk("term_berr", bus.SCSI_BERR_n, 1);
          chk("term_fcs", bus.FCS_n_out, 0);
          chk("term_doe", bus.DOE, !rd);
        end
        bus.DTACK_n = 1'b1;
        bus.BERR_n  = 1'b1;
      end
      tick();
    end

    chk("rec_fcs", bus.FCS_n_out, 1);
    chk("rec_ds", bus.DS_n_out, 4'hF);
    chk("rec_doe", bus.DOE, 0);
    chk("rec_sterm", bus.SCSI_STERM_n, 1);
    chk("rec_berr", bus.SCSI_BERR_n, 1);
    chk("rec_dlatch", bus.DLATCH, 0);
    chk("rec_err", bus.cyc_err, 0);
    chk("rec_busy", bus.busy, 1);
    repeat (RECOVERY) tick();
    chk("idle_busy", bus.busy, 0);
    chk("idle_drive_en", bus.drive_en, 0);
    repeat (hold) begin
      tick();
      chk("no_rearm_fcs", bus.FCS_n_out, 1);
    end
    bus.cyc_req = 1'b0;
    tick();
    chk("drop_fcs", bus.FCS_n_out, 1);
  endtask

  initial begin
    bus.BMASTER  = 1'b1;
    bus.cyc_req  = 1'b0;
    bus.cyc_read = 1'b0;
    bus.cyc_siz  = 2'b00;
    bus.cyc_a    = 2'b00;
    bus.DTACK_n  = 1'b1;
    bus.BERR_n   = 1'b1;
    RESET_n      = 1'b0;
    repeat (3) tick();
    chk_reset_vals("por");
    RESET_n = 1'b1;
    tick();

    run_cycle(K_DTACK,   0, 0, 1'b1, 2, 0);
    run_cycle(K_DTACK,   1, 2, 1'b0, 1, 1);
    run_cycle(K_TIMEOUT, 2, 0, 1'b1, 0, 0);
    run_cycle(K_BOTH,    0, 0, 1'b0, 1, 0);
    run_cycle(K_BMDROP,  2, 2, 1'b1, 2, 0);

    // Reset asserted while the cycle sits in ADDR.
    bus.cyc_req  = 1'b1;
    bus.cyc_siz  = 2'b00;
    bus.cyc_a    = 2'b00;
    bus.cyc_read = 1'b0;
    tick();
    chk("rst_pre_fcs", bus.FCS_n_out, 0);
    RESET_n = 1'b0;
    tick();
    chk_reset_vals("midrst");
    bus.cyc_req = 1'b0;
    tick();
    RESET_n = 1'b1;
    tick();

    run_cycle(K_DTACK, 3, 1, 1'b1, 1, 18);
    run_cycle(K_STALE, 1, 1, 1'b1, 0, 0);

    for (int it = 0; it < 16; it++) begin
      run_cycle(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
